// File: rtl/stage_ctrl_pkg.sv
// rtl/stage_ctrl_pkg.sv - RV32I opcode constants, sequencer state encodings and decode helpers
package stage_ctrl_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_R      = 7'b0110011;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_TRAP = 3'd5
    } state_t;

    // Opcodes this core executes; anything else traps
    function automatic logic op_legal(input logic [6:0] op);
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
            OP_LOAD, OP_STORE, OP_I, OP_R: op_legal = 1'b1;
            default:                       op_legal = 1'b0;
        endcase
    endfunction

    // Opcodes that produce a register-file result
    function automatic logic op_writes_rd(input logic [6:0] op);
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
            OP_LOAD, OP_I, OP_R: op_writes_rd = 1'b1;
            default:             op_writes_rd = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/stage_ctrl_perf_cnt.sv
// rtl/stage_ctrl_perf_cnt.sv - free-running cycle and retired-instruction counters
module perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        retire,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
);

    // Cycle counter runs on every out-of-reset cycle and wraps naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    // Retire counter only updates on writeback so a held value stays put otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            instret_cnt <= '0;
        end else if (retire) begin
            instret_cnt <= instret_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/stage_ctrl.sv
// rtl/stage_ctrl.sv - multicycle IF/ID/EX/MEM/WB sequencer; STAGE_CTRL_PERF_EN adds perf counters
module stage_ctrl
    import stage_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        ir_we,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        rf_we,
    output logic        pc_we,
    output logic [2:0]  stage,
    output logic        err,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
);

    state_t     state;
    logic [6:0] opcode;
    logic       is_mem;
    logic       is_store;
    logic       rd_nonzero;
    logic       unused_inst_hi;

    assign opcode         = inst[6:0];
    assign is_store       = (opcode == OP_STORE);
    assign is_mem         = (opcode == OP_LOAD) || is_store;
    assign rd_nonzero     = (inst[11:7] != 5'd0);
    assign unused_inst_hi = ^inst[31:12];
    assign stage          = state;

    // State register: one step per cycle, stalls only in IF and MEM, trap is terminal until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IF;
        end else begin
            case (state)
                S_IF:    if (imem_ready) state <= S_ID;
                S_ID:    state <= op_legal(opcode) ? S_EX : S_TRAP;
                S_EX:    state <= is_mem ? S_MEM : S_WB;
                S_MEM:   if (dmem_ready) state <= S_WB;
                S_WB:    state <= S_IF;
                S_TRAP:  state <= S_TRAP;
                default: state <= S_TRAP;
            endcase
        end
    end

    // Handshakes and enables decode from state and inst; reset forces them all low
    always_comb begin
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        pc_we    = 1'b0;
        err      = 1'b0;
        if (!rst) begin
            case (state)
                S_IF: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ready;
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = is_store;
                end
                S_WB: begin
                    pc_we = 1'b1;
                    rf_we = op_writes_rd(opcode) && rd_nonzero;
                end
                S_TRAP:  err = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef STAGE_CTRL_PERF_EN
    logic retire;
    assign retire = (state == S_WB) && !rst;

    perf_cnt u_perf_cnt (
        .clk         (clk),
        .rst         (rst),
        .retire      (retire),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_stage_ctrl.sv
// tb/tb_stage_ctrl.sv - scoreboard bench for stage_ctrl
module tb_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst = 32'h0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, err;
    logic [2:0]  stage;
    logic [31:0] cycle_cnt, instret_cnt;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int lat;
        bit rf;
    } exp_t;
    exp_t exp_q[$];

    int cyc = 0;
    int ir_n = 0;

    localparam logic [31:0] I_ADDI = 32'h00100093;
    localparam logic [31:0] I_SW   = 32'h00112023;
    localparam logic [31:0] I_LW   = 32'h00002283;
    localparam logic [31:0] I_BEQ  = 32'h00000063;
    localparam logic [31:0] I_JAL  = 32'h000000EF;
    localparam logic [31:0] I_LUI0 = 32'h00000037;
    localparam logic [31:0] I_BAD  = 32'h0000007F;

    stage_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .inst        (inst),
        .imem_ready  (imem_ready),
        .dmem_ready  (dmem_ready),
        .imem_req    (imem_req),
        .ir_we       (ir_we),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .rf_we       (rf_we),
        .pc_we       (pc_we),
        .stage       (stage),
        .err         (err),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );

    always #5 clk = ~clk;

    function automatic bit model_rf(input logic [31:0] ins);
        logic [6:0] op;
        bit w;
        op = ins[6:0];
        case (op)
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
            7'b0000011, 7'b0010011, 7'b0110011: w = 1'b1;
            default: w = 1'b0;
        endcase
        return w && (ins[11:7] != 5'd0);
    endfunction

    // Retirement monitor: pops the scoreboard on every pc_we pulse
    always @(negedge clk) begin
        if (rst) begin
            cyc  = 0;
            ir_n = 0;
        end else begin
            cyc++;
            if (ir_we === 1'b1) ir_n++;
            if (rf_we === 1'b1 && pc_we !== 1'b1) begin
                vectors++; miscompares++;
                $display("FAIL rf_without_pc: rf_we=1 pc_we=%b", pc_we);
            end
            if (pc_we === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_retire: pc_we=1 with empty scoreboard");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (cyc !== e.lat || rf_we !== e.rf || ir_n !== 1) begin
                        miscompares++;
                        $display("FAIL retire: latency=%0d rf_we=%b ir_we_count=%0d, required latency=%0d rf_we=%b ir_we_count=1",
                                 cyc, rf_we, ir_n, e.lat, e.rf);
                    end
                end
                cyc  = 0;
                ir_n = 0;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic exec(input logic [31:0] ins, input int iw, input int dw);
        exp_t e;
        bit done;
        bit st;
        st = (ins[6:0] == 7'b0100011);
        e.lat = 4 + iw + dw + (((ins[6:0] == 7'b0000011) || st) ? 1 : 0);
        e.rf  = model_rf(ins);
        exp_q.push_back(e);
        inst = ins;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            imem_ready = (iw == 0);
            dmem_ready = (dw == 0);
            @(negedge clk);
            if (stage === 3'd3) begin
                vectors++;
                if (dmem_req !== 1'b1 || dmem_we !== st) begin
                    miscompares++;
                    $display("FAIL dmem_hold: dmem_req=%b dmem_we=%b, required 1 %b", dmem_req, dmem_we, st);
                end
                if (dw > 0) dw--;
            end
            if (stage === 3'd0 && iw > 0) iw--;
            if (pc_we === 1'b1) done = 1'b1;
            @(posedge clk);
            #1;
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL exec_timeout: inst=%h retired=0 required=1", ins);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        inst = I_ADDI;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, err} !== 7'b0 || stage !== 3'd0) begin
                miscompares++;
                $display("FAIL reset_outputs: enables=%b stage=%0d, required 0000000 stage=0",
                         {imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, err}, stage);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        imem_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (stage !== 3'd0 || imem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release: stage=%0d imem_req=%b, required 0 1", stage, imem_req);
        end
    endtask

    task automatic test_zero_wait();
        do_reset();
        exec(I_ADDI, 0, 0);
        exec(I_SW, 0, 0);
    endtask

    task automatic test_back_to_back();
        exec(I_BEQ, 0, 0);
        exec(I_JAL, 0, 0);
        exec(I_ADDI, 1, 0);
    endtask

    task automatic test_wait_states();
        exec(I_LW, 2, 3);
    endtask

    task automatic test_rd_x0();
        exec(I_LUI0, 0, 0);
    endtask

    task automatic test_illegal();
        inst = I_BAD;
        imem_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (stage !== 3'd0) begin
            miscompares++;
            $display("FAIL illegal_if: stage=%0d required 0", stage);
        end
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (stage !== 3'd1) begin
            miscompares++;
            $display("FAIL illegal_id: stage=%0d required 1", stage);
        end
        dmem_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            vectors++;
            if (stage !== 3'd5 || err !== 1'b1 ||
                {imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we} !== 6'b0) begin
                miscompares++;
                $display("FAIL trap_hold: cycle=%0d stage=%0d err=%b enables=%b, required stage=5 err=1 enables=000000",
                         i, stage, err, {imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we});
            end
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL trap_reset_err: err=%b required 0", err);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        imem_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (stage !== 3'd0 || err !== 1'b0 || imem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL trap_recover: stage=%0d err=%b imem_req=%b, required 0 0 1", stage, err, imem_req);
        end
    endtask

    task automatic test_reset_in_mem();
        bit reached;
        do_reset();
        inst = I_LW;
        imem_ready = 1'b1;
        dmem_ready = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 10 && !reached; i++) begin
            @(negedge clk);
            if (stage === 3'd3) reached = 1'b1;
            @(posedge clk); #1;
        end
        vectors++;
        if (!reached) begin
            miscompares++;
            $display("FAIL mem_reach: stage=%0d required 3", stage);
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({dmem_req, rf_we, pc_we, err} !== 4'b0) begin
            miscompares++;
            $display("FAIL mem_reset_outputs: dmem_req,rf_we,pc_we,err=%b required 0000", {dmem_req, rf_we, pc_we, err});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (stage !== 3'd0 || imem_req !== 1'b1 || pc_we !== 1'b0 || dmem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL mem_reset_release: stage=%0d imem_req=%b pc_we=%b dmem_req=%b, required 0 1 0 0",
                     stage, imem_req, pc_we, dmem_req);
        end
    endtask

    task automatic test_perf();
        do_reset();
        exec(I_ADDI, 0, 0);
        exec(I_ADDI, 0, 0);
        exec(I_ADDI, 0, 0);
`ifdef STAGE_CTRL_PERF_EN
        vectors++;
        if (instret_cnt !== 32'd3 || cycle_cnt !== 32'd12) begin
            miscompares++;
            $display("FAIL perf_counts: instret=%0d cycle=%0d, required 3 12", instret_cnt, cycle_cnt);
        end
        do_reset();
        force dut.u_perf_cnt.instret_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.u_perf_cnt.instret_cnt;
        exec(I_ADDI, 0, 0);
        vectors++;
        if (instret_cnt !== 32'd0 || cycle_cnt !== 32'd4) begin
            miscompares++;
            $display("FAIL perf_wrap: instret=%h cycle=%0d, required 00000000 4", instret_cnt, cycle_cnt);
        end
`else
        vectors++;
        if (instret_cnt !== 32'd0 || cycle_cnt !== 32'd0) begin
            miscompares++;
            $display("FAIL perf_tied: instret=%0d cycle=%0d, required 0 0", instret_cnt, cycle_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_back_to_back();
        test_wait_states();
        test_rd_x0();
        test_illegal();
        test_reset_in_mem();
        test_perf();
        @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
